// File: rtl/tcp_vlg_tx_arb.sv
// rtl/tcp_vlg_tx_arb.sv - whole-packet round-robin arbiter onto the TCP transmit stream
//
// Purpose:
//   Grants one of N_SRC packet sources at a time (SOF..EOF), muxes its byte
//   lane onto tx_*, enforces GAP_TICKS idle cycles between packets and aborts
//   a granted source that withholds bytes for too long mid-packet.
//
// Ports:
//   clk, rst             clock, asynchronous active-low reset
//   src_req[N]           source has a complete packet pending
//   src_gnt[N]           registered one-hot grant
//   src_rdy[N]           per-source ready (grant & tx_rdy while transferring)
//   src_dat/val/sof/eof  flattened per-source byte lanes
//   src_meta             flattened per-source metadata words
//   tx_dat/val/sof/eof   muxed byte stream toward IPv4
//   tx_meta              metadata of the granted source, latched on grant
//   tx_rdy               downstream ready
//   tx_err               one-cycle pulse on watchdog abort
//   busy                 high whenever not IDLE
//
// Optional feature macro: TCP_VLG_TX_ARB_PRIO0_EN
//   When defined, source 0 wins every arbitration it requests in; the
//   round-robin pointer then rotates over sources 1..N_SRC-1 only.

module tcp_vlg_tx_arb #(
  parameter int N_SRC       = 3,
  parameter int META_W      = 128,
  parameter int GAP_TICKS   = 4,
  parameter int STALL_TICKS = 1000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_SRC-1:0]         src_req,
  output logic [N_SRC-1:0]         src_gnt,
  output logic [N_SRC-1:0]         src_rdy,
  input  logic [8*N_SRC-1:0]       src_dat,
  input  logic [N_SRC-1:0]         src_val,
  input  logic [N_SRC-1:0]         src_sof,
  input  logic [N_SRC-1:0]         src_eof,
  input  logic [META_W*N_SRC-1:0]  src_meta,
  output logic [7:0]               tx_dat,
  output logic                     tx_val,
  output logic                     tx_sof,
  output logic                     tx_eof,
  output logic [META_W-1:0]        tx_meta,
  input  logic                     tx_rdy,
  output logic                     tx_err,
  output logic                     busy
);

  localparam int IDX_W    = $clog2(N_SRC);
  localparam int STL_W    = $clog2(STALL_TICKS + 1);
  localparam int GAP_W    = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
  localparam int GAP_LAST = (GAP_TICKS > 0) ? GAP_TICKS - 1 : 0;
  localparam int STL_LAST = (STALL_TICKS > 0) ? STALL_TICKS - 1 : 0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_XFER  = 2'd1,
    S_ABORT = 2'd2,
    S_GAP   = 2'd3
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [N_SRC-1:0]    r_gnt, w_gnt_nxt;
  logic [IDX_W-1:0]    r_idx, w_idx_nxt;
  logic [IDX_W-1:0]    r_rr, w_rr_nxt;
  logic [META_W-1:0]   r_meta, w_meta_nxt;
  logic [STL_W-1:0]    r_stall, w_stall_nxt;
  logic [GAP_W-1:0]    r_gap, w_gap_nxt;

  logic [N_SRC-1:0]    w_req_scan;
  logic [N_SRC-1:0]    w_pick_oh;
  logic [IDX_W-1:0]    w_pick;
  logic                w_found;
  logic [META_W-1:0]   w_pick_meta;
  logic [IDX_W-1:0]    w_rr_adv;
  logic [STL_W-1:0]    w_stall_inc;

  logic [7:0]          w_lane_dat;
  logic                w_lane_val;
  logic                w_lane_sof;
  logic                w_lane_eof;

  // First requester at or after the RR pointer, wrapping.
  always_comb begin
    int j;
    w_req_scan = src_req;
`ifdef TCP_VLG_TX_ARB_PRIO0_EN
    // Source 0 is handled by the priority override below, not the rotation.
    w_req_scan[0] = 1'b0;
`endif
    w_found   = 1'b0;
    w_pick    = '0;
    w_pick_oh = '0;
    for (int k = 0; k < N_SRC; k++) begin
      j = int'(r_rr) + k;
      if (j >= N_SRC) j = j - N_SRC;
      if (!w_found && w_req_scan[j]) begin
        w_found      = 1'b1;
        w_pick       = IDX_W'(j);
        w_pick_oh[j] = 1'b1;
      end
    end
`ifdef TCP_VLG_TX_ARB_PRIO0_EN
    if (src_req[0]) begin
      w_found   = 1'b1;
      w_pick    = '0;
      w_pick_oh = N_SRC'(1);
    end
`endif
  end

  always_comb begin
    w_pick_meta = '0;
    for (int k = 0; k < N_SRC; k++) begin
      if (w_pick_oh[k]) w_pick_meta = src_meta[k*META_W +: META_W];
    end
  end

  // One-hot grant mux; non-granted lanes contribute nothing.
  always_comb begin
    w_lane_dat = '0;
    w_lane_val = 1'b0;
    w_lane_sof = 1'b0;
    w_lane_eof = 1'b0;
    for (int k = 0; k < N_SRC; k++) begin
      if (r_gnt[k]) begin
        w_lane_dat = src_dat[k*8 +: 8];
        w_lane_val = src_val[k];
        w_lane_sof = src_sof[k];
        w_lane_eof = src_eof[k];
      end
    end
  end

  always_comb begin
    w_rr_adv = (r_idx == IDX_W'(N_SRC - 1)) ? '0 : r_idx + IDX_W'(1);
`ifdef TCP_VLG_TX_ARB_PRIO0_EN
    // Priority grants to source 0 leave the rotation untouched.
    if (r_idx == '0) w_rr_adv = r_rr;
`endif
  end

  assign w_stall_inc = r_stall + STL_W'(1);

  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_idx_nxt   = r_idx;
    w_rr_nxt    = r_rr;
    w_meta_nxt  = r_meta;
    w_stall_nxt = r_stall;
    w_gap_nxt   = r_gap;
    tx_dat      = '0;
    tx_val      = 1'b0;
    tx_sof      = 1'b0;
    tx_eof      = 1'b0;
    tx_err      = 1'b0;
    src_rdy     = '0;

    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_gnt_nxt   = w_pick_oh;
          w_idx_nxt   = w_pick;
          w_meta_nxt  = w_pick_meta;
          w_stall_nxt = '0;
          w_state_nxt = S_XFER;
        end
      end

      S_XFER: begin
        tx_dat  = w_lane_dat;
        tx_val  = w_lane_val;
        tx_sof  = w_lane_sof;
        tx_eof  = w_lane_eof;
        src_rdy = r_gnt & {N_SRC{tx_rdy}};
        if (w_lane_val && tx_rdy) begin
          w_stall_nxt = '0;
          if (w_lane_eof) begin
            w_gnt_nxt   = '0;
            w_rr_nxt    = w_rr_adv;
            w_gap_nxt   = '0;
            w_state_nxt = (GAP_TICKS == 0) ? S_IDLE : S_GAP;
          end
        end else if (!w_lane_val) begin
          // Backpressure with data present is not a stall; only a silent
          // source advances the watchdog.
          w_stall_nxt = w_stall_inc;
          if (w_stall_inc >= STL_W'(STL_LAST)) w_state_nxt = S_ABORT;
        end
      end

      S_ABORT: begin
        // Forced terminator so downstream can close and drop the frame.
        tx_val      = 1'b1;
        tx_eof      = 1'b1;
        tx_err      = 1'b1;
        w_gnt_nxt   = '0;
        w_rr_nxt    = w_rr_adv;
        w_stall_nxt = '0;
        w_gap_nxt   = '0;
        w_state_nxt = (GAP_TICKS == 0) ? S_IDLE : S_GAP;
      end

      S_GAP: begin
        if (r_gap == GAP_W'(GAP_LAST)) w_state_nxt = S_IDLE;
        else                           w_gap_nxt   = r_gap + GAP_W'(1);
      end

      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_gnt   <= '0;
      r_idx   <= '0;
      r_rr    <= '0;
      r_meta  <= '0;
      r_stall <= '0;
      r_gap   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_gnt   <= w_gnt_nxt;
      r_idx   <= w_idx_nxt;
      r_rr    <= w_rr_nxt;
      r_meta  <= w_meta_nxt;
      r_stall <= w_stall_nxt;
      r_gap   <= w_gap_nxt;
    end
  end

  assign src_gnt = r_gnt;
  assign tx_meta = r_meta;
  assign busy    = (r_state != S_IDLE);

endmodule

// File: tb/tb_tcp_vlg_tx_arb.sv
// tb/tb_tcp_vlg_tx_arb.sv - directed self-checking bench for tcp_vlg_tx_arb

module tb_tcp_vlg_tx_arb;

  localparam int NS = 3;
  localparam int MW = 128;
  localparam int GT = 4;
  localparam int ST = 1000;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NS-1:0]     src_req;
  logic [NS-1:0]     src_gnt;
  logic [NS-1:0]     src_rdy;
  logic [8*NS-1:0]   src_dat;
  logic [NS-1:0]     src_val;
  logic [NS-1:0]     src_sof;
  logic [NS-1:0]     src_eof;
  logic [MW*NS-1:0]  src_meta;
  logic [7:0]        tx_dat;
  logic              tx_val;
  logic              tx_sof;
  logic              tx_eof;
  logic [MW-1:0]     tx_meta;
  logic              tx_rdy;
  logic              tx_err;
  logic              busy;

  int total = 0;
  int bad   = 0;

  int len[NS], pos[NS], npk[NS], pkt[NS], drop_at[NS];
  bit x[NS];
  int rdy_mode;

  int order[$];
  int gaps[$];
  int gap_cur, n_xfer, n_err, gcyc, stall_run, stall_at_err;
  logic       err_val, err_eof;
  logic [7:0] err_dat;
  logic [NS-1:0] prev_gnt;

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL sim_timeout");
    $fatal(1);
  end

  tcp_vlg_tx_arb #(
    .N_SRC(NS), .META_W(MW), .GAP_TICKS(GT), .STALL_TICKS(ST)
  ) dut (
    .clk(clk), .rst(rst),
    .src_req(src_req), .src_gnt(src_gnt), .src_rdy(src_rdy),
    .src_dat(src_dat), .src_val(src_val), .src_sof(src_sof), .src_eof(src_eof),
    .src_meta(src_meta),
    .tx_dat(tx_dat), .tx_val(tx_val), .tx_sof(tx_sof), .tx_eof(tx_eof),
    .tx_meta(tx_meta), .tx_rdy(tx_rdy), .tx_err(tx_err), .busy(busy)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] bytev(int s, int p, int i);
    return 8'(s*80 + p*17 + i + 1);
  endfunction

  function automatic logic [127:0] metav(int s, int p);
    return {32'hC0DE_0000 + 32'(s), 32'(p), 64'hA5A5_0000_1234_5678 ^ 64'(s*31 + p)};
  endfunction

  function automatic int ord(int i);
    return (i < order.size()) ? order[i] : -1;
  endfunction

  function automatic int gap(int i);
    return (i < gaps.size()) ? gaps[i] : -1;
  endfunction

  function automatic bit all_done();
    return (npk[0] + npk[1] + npk[2] == 0) && !busy;
  endfunction

  // Granted sources present real bytes; waiting sources put junk on their
  // lanes (val high) which the arbiter must ignore.
  task automatic drive();
    for (int s = 0; s < NS; s++) begin
      bit act;
      act = src_gnt[s] && (npk[s] > 0) && (pos[s] != drop_at[s]);
      src_req[s] = (npk[s] > 0);
      if (act) begin
        src_val[s] = 1'b1;
        src_dat[s*8 +: 8] = bytev(s, pkt[s], pos[s]);
        src_sof[s] = (pos[s] == 0);
        src_eof[s] = (pos[s] == len[s] - 1);
      end else if (npk[s] > 0 && !src_gnt[s]) begin
        src_val[s] = 1'b1;
        src_dat[s*8 +: 8] = 8'hEE;
        src_sof[s] = 1'b1;
        src_eof[s] = 1'b1;
      end else begin
        src_val[s] = 1'b0;
        src_dat[s*8 +: 8] = 8'h00;
        src_sof[s] = 1'b0;
        src_eof[s] = 1'b0;
      end
      src_meta[s*MW +: MW] = metav(s, pkt[s]);
    end
    if (rdy_mode == 1) tx_rdy = (src_gnt != 0) ? ~tx_rdy : 1'b1;
    else               tx_rdy = 1'b1;
  endtask

  task automatic monitor();
    int gs;
    gs = -1;
    for (int s = 0; s < NS; s++) begin
      if (src_gnt[s]) gs = s;
      x[s] = src_rdy[s] & src_val[s];
    end
    if (src_gnt != 0 && src_gnt != prev_gnt && gs >= 0) begin
      order.push_back(gs);
      check("meta", tx_meta, metav(gs, pkt[gs]));
    end
    prev_gnt = src_gnt;
    if (busy && src_gnt == 0) gap_cur++;
    else if (gap_cur > 0) begin
      gaps.push_back(gap_cur);
      gap_cur = 0;
    end
    if (src_gnt != 0) gcyc++;
    if (tx_err) begin
      n_err++;
      err_val = tx_val;
      err_eof = tx_eof;
      err_dat = tx_dat;
      stall_at_err = stall_run;
      stall_run = 0;
      if (gs >= 0) begin
        npk[gs] = 0;
        pos[gs] = 0;
        drop_at[gs] = -1;
      end
    end else if (tx_val && tx_rdy) begin
      n_xfer++;
      stall_run = 0;
      if (gs >= 0)
        check("byte", {tx_sof, tx_eof, tx_dat},
              {1'(pos[gs] == 0), 1'(pos[gs] == len[gs] - 1), bytev(gs, pkt[gs], pos[gs])});
    end else if (src_gnt != 0 && !tx_val) begin
      stall_run++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    for (int s = 0; s < NS; s++) begin
      if (x[s]) begin
        if (pos[s] == len[s] - 1) begin
          pos[s] = 0;
          pkt[s]++;
          npk[s]--;
        end else begin
          pos[s]++;
        end
      end
    end
    drive();
    @(negedge clk);
    monitor();
  endtask

  task automatic clear_stats();
    order.delete();
    gaps.delete();
    gap_cur = 0; n_xfer = 0; n_err = 0; gcyc = 0;
    stall_run = 0; stall_at_err = -1;
    err_val = 1'b0; err_eof = 1'b0; err_dat = 8'hFF;
    prev_gnt = '0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    for (int s = 0; s < NS; s++) begin
      npk[s] = 0; pos[s] = 0; pkt[s] = 0; drop_at[s] = -1; len[s] = 1; x[s] = 1'b0;
    end
    rdy_mode = 0;
    tx_rdy = 1'b1;
    tick();
    tick();
    rst = 1'b1;
    clear_stats();
  endtask

  task automatic run(input string tag, input int maxc);
    int n;
    n = 0;
    while (!all_done() && n < maxc) begin
      tick();
      n++;
    end
    check(tag, all_done(), 1);
  endtask

  initial begin
    int n;
    src_req = '0; src_val = '0; src_sof = '0; src_eof = '0;
    src_dat = '0; src_meta = '0; tx_rdy = 1'b1;
    for (int s = 0; s < NS; s++) begin
      npk[s] = 0; pos[s] = 0; pkt[s] = 0; drop_at[s] = -1; len[s] = 1; x[s] = 1'b0;
    end
    rdy_mode = 0;
    clear_stats();

    // reset state
    #2 rst = 1'b0;
    #1;
    check("rst_gnt",  src_gnt, 0);
    check("rst_val",  tx_val,  0);
    check("rst_dat",  tx_dat,  0);
    check("rst_meta", tx_meta, 0);
    check("rst_err",  tx_err,  0);
    check("rst_busy", busy,    0);
    do_reset();

    // single source 1, 60 bytes
    npk[1] = 1; len[1] = 60;
    tick();
    check("t1_gnt_pre", src_gnt, 3'b000);
    tick();
    check("t1_gnt", src_gnt, 3'b010);
    run("t1_done", 200);
    check("t1_xfer", n_xfer, 60);
    check("t1_ngap", gaps.size(), 1);
    check("t1_gap",  gap(0), GT);
    check("t1_busy", busy, 0);
    check("t1_err",  n_err, 0);

    // all three saturating, two 10-byte packets each
    do_reset();
    for (int s = 0; s < NS; s++) begin npk[s] = 2; len[s] = 10; end
    run("t2_done", 400);
    check("t2_xfer", n_xfer, 60);
    check("t2_nord", order.size(), 6);
    for (int i = 0; i < 6; i++) check("t2_ord", ord(i), i % 3);
    check("t2_ngap", gaps.size(), 6);
    for (int i = 0; i < 6; i++) check("t2_gap", gap(i), GT);

    // tx_rdy toggling during a 20-byte packet
    do_reset();
    rdy_mode = 1;
    npk[2] = 1; len[2] = 20;
    run("t3_done", 200);
    check("t3_xfer", n_xfer, 20);
    check("t3_cyc",  gcyc, 40);
    check("t3_err",  n_err, 0);
    rdy_mode = 0;

    // source 0 stalls after 5 bytes, source 1 waiting
    do_reset();
    npk[0] = 1; len[0] = 10; drop_at[0] = 5;
    npk[1] = 1; len[1] = 4;
    run("t4_done", 3000);
    check("t4_nerr",  n_err, 1);
    check("t4_stall", stall_at_err, 999);
    check("t4_val",   err_val, 1);
    check("t4_eof",   err_eof, 1);
    check("t4_dat",   err_dat, 0);
    check("t4_xfer",  n_xfer, 9);
    check("t4_nord",  order.size(), 2);
    check("t4_ord0",  ord(0), 0);
    check("t4_ord1",  ord(1), 1);
    check("t4_gap",   gap(0), GT);

    // async reset mid-packet, then arbitration restarts at source 0
    do_reset();
    npk[1] = 2; len[1] = 10;
    n = 0;
    while (n_xfer < 17 && n < 100) begin
      tick();
      n++;
    end
    check("t5_reach", n_xfer, 17);
    #2 rst = 1'b0;
    #1;
    check("t5_gnt",  src_gnt, 0);
    check("t5_rdy",  src_rdy, 0);
    check("t5_val",  tx_val,  0);
    check("t5_eof",  tx_eof,  0);
    check("t5_meta", tx_meta, 0);
    check("t5_busy", busy,    0);
    do_reset();
    for (int s = 0; s < NS; s++) begin npk[s] = 1; len[s] = 3; end
    run("t5_done", 200);
    check("t5_nord", order.size(), 3);
    check("t5_ord0", ord(0), 0);
    check("t5_ord1", ord(1), 1);
    check("t5_ord2", ord(2), 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
